// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring on magnitudes) producing HI and LO.
// ITERS must equal WIDTH; one iteration per clock, result lands on the last iteration edge.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             a_neg_q, a_neg_d;
  logic             b_neg_q, b_neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  // Booth step datapath; the accumulator carries one guard bit so -M never overflows.
  logic [WIDTH:0]   m_ext, booth_sum, booth_acc;
  logic [WIDTH-1:0] booth_q;
  logic             booth_qm1;

  always_comb begin
    m_ext     = {m_q[WIDTH-1], m_q};
    booth_sum = acc_q;
    case ({q_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + m_ext;
      2'b10:   booth_sum = acc_q - m_ext;
      default: booth_sum = acc_q;
    endcase
    booth_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
    booth_q   = {booth_sum[0], q_q[WIDTH-1:1]};
    booth_qm1 = q_q[0];
  end

  // Restoring divide step: shift remainder left, trial-subtract the divisor magnitude.
  logic [WIDTH:0]   rem_sh, rem_diff, div_acc;
  logic [WIDTH-1:0] div_q, quo_signed, rem_signed;

  always_comb begin
    rem_sh   = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, m_q};
    if (!rem_diff[WIDTH]) begin
      div_acc = rem_diff;
      div_q   = {q_q[WIDTH-2:0], 1'b1};
    end else begin
      div_acc = rem_sh;
      div_q   = {q_q[WIDTH-2:0], 1'b0};
    end
    quo_signed = (a_neg_q ^ b_neg_q) ? -div_q : div_q;
    rem_signed = a_neg_q ? -div_acc[WIDTH-1:0] : div_acc[WIDTH-1:0];
  end

  logic [WIDTH-1:0] a_abs, b_abs;
  assign a_abs = a_in[WIDTH-1] ? -a_in : a_in;
  assign b_abs = b_in[WIDTH-1] ? -b_in : b_in;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    m_d     = m_q;
    a_neg_d = a_neg_q;
    b_neg_d = b_neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    dz_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = '0;
          acc_d   = '0;
          qm1_d   = 1'b0;
          a_neg_d = a_in[WIDTH-1];
          b_neg_d = b_in[WIDTH-1];
          if (!op) begin
            q_d     = b_in;
            m_d     = a_in;
            state_d = MULT;
            busy_d  = 1'b1;
          end else if (b_in != '0) begin
            q_d     = a_abs;
            m_d     = b_abs;
            state_d = DIV;
            busy_d  = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            dz_d    = 1'b1;
          end
        end
      end
      MULT: begin
        acc_d = booth_acc;
        q_d   = booth_q;
        qm1_d = booth_qm1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          hi_d    = booth_acc[WIDTH-1:0];
          lo_d    = booth_q;
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      DIV: begin
        acc_d = div_acc;
        q_d   = div_q;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          hi_d    = rem_signed;
          lo_d    = quo_signed;
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      m_q     <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      m_q     <= m_d;
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: vector table plus reset-abort, divide-by-zero and held-start sequences.
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a_in, b_in;
  logic [31:0] hi_out, lo_out;
  logic        busy, done, div_zero;

  int n_cmp = 0;
  int n_bad = 0;

  mult_div_unit #(.WIDTH(32), .ITERS(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .a_in(a_in), .b_in(b_in), .hi_out(hi_out), .lo_out(lo_out),
    .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Issue one op; lat is the number of edges after the issue edge before done is seen.
  task automatic run(input logic o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ehi, input logic [31:0] elo, input logic edz,
                     input int elat, input logic hold);
    int n;
    start = 1'b1; op = o; a_in = a; b_in = b;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    chk("busy_after_issue", {31'b0, busy}, {31'b0, (elat != 0)});
    n = 0;
    while (!done && n < 40) begin
      if (hold && n == 5) begin
        op = ~o; a_in = 32'h13579BDF; b_in = 32'h0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk("latency", n, elat);
    chk("hi", hi_out, ehi);
    chk("lo", lo_out, elo);
    chk("div_zero", {31'b0, div_zero}, {31'b0, edz});
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h dz=%b lat=%0d", o, a, b, hi_out, lo_out, div_zero, n);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'b0, done}, 32'd0);
    chk("busy_after_done", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("no_reissue", {30'b0, busy, done}, 32'd0);
  endtask

  initial begin
    int n;
    int dones;
    vecs[0]  = '{1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[2]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[3]  = '{1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
    vecs[4]  = '{1'b0, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};
    vecs[5]  = '{1'b0, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[6]  = '{1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[7]  = '{1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8]  = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
    vecs[9]  = '{1'b1, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    vecs[10] = '{1'b1, 32'h00000003, 32'h00000007, 32'h00000003, 32'h00000000};
    vecs[11] = '{1'b1, 32'h80000000, 32'h00000002, 32'h00000000, 32'hC0000000};
    vecs[12] = '{1'b1, 32'h80000000, 32'h00000001, 32'h00000000, 32'h80000000};

    reset = 1'b1; start = 1'b0; op = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hi", hi_out, 32'd0);
    chk("reset_lo", lo_out, 32'd0);
    chk("reset_flags", {29'b0, busy, done, div_zero}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++)
      run(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b0, 32, 1'b0);

    // Reset mid-multiply: abort with no update and no done pulse.
    start = 1'b1; op = 1'b0; a_in = 32'h00000005; b_in = 32'h00000006;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_hi", hi_out, 32'd0);
    chk("abort_lo", lo_out, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    dones = 0;
    for (n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (done || busy) dones++;
    end
    chk("abort_no_done", dones, 0);
    $display("reset mid-mult -> hi=%h lo=%h busy=%b", hi_out, lo_out, busy);

    run(1'b1, 32'h00000005, 32'h00000002, 32'h00000001, 32'h00000002, 1'b0, 32, 1'b0);
    run(1'b1, 32'h00000005, 32'h00000000, 32'h00000001, 32'h00000002, 1'b1, 0, 1'b0);
    run(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 32, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
